// File: rtl/simon_pkg.sv
// simon_pkg: colour codes, playback state encoding and the colour-to-LED decode.
package simon_pkg;

    localparam logic [1:0] COL_B = 2'b00;
    localparam logic [1:0] COL_G = 2'b01;
    localparam logic [1:0] COL_R = 2'b10;
    localparam logic [1:0] COL_Y = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ON    = 3'd2;
    localparam logic [2:0] S_OFF   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_FETCH = S_FETCH,
        ST_ON    = S_ON,
        ST_OFF   = S_OFF,
        ST_DONE  = S_DONE
    } state_e;

    function automatic logic [3:0] onehot_colour(input logic [1:0] c);
        return (c == COL_B) ? 4'b0001 :
               (c == COL_G) ? 4'b0010 :
               (c == COL_R) ? 4'b0100 :
               (c == COL_Y) ? 4'b1000 : 4'b0000;
    endfunction

endpackage

// File: rtl/play_timer.sv
// play_timer: loadable down-counter that parks at zero; shared by the ON and OFF phases.
module play_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);

    always_comb cnt_d = load ? load_val : zero ? cnt_q : cnt_q - CNT_W'(1);

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays the stored colour sequence as timed one-hot LED flashes.
module sequence_player
    import simon_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int CNT_W      = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   step
);

    localparam logic [ADDR_W:0]  MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    state_e            state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        led_q;
    logic              busy_q, done_q;
    logic              tmr_load, tmr_zero, last;
    logic [CNT_W-1:0]  tmr_val;

    always_comb begin
        tmr_load = (state_q == ST_FETCH) || (state_q == ST_ON && tmr_zero);
        tmr_val  = (state_q == ST_FETCH) ? ON_LOAD : OFF_LOAD;
        last     = ({1'b0, addr_q} == len_q - (ADDR_W+1)'(1));
    end

    play_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // The memory address doubles as the step index; it is held after abort until the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:
                    if (start && length != '0) begin
                        len_q   <= (length > MAX_LEN) ? MAX_LEN : length;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end else if (start) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                ST_FETCH: begin
                    led_q   <= onehot_colour(mem_data);
                    state_q <= ST_ON;
                end
                ST_ON:
                    if (tmr_zero) begin
                        led_q   <= '0;
                        state_q <= ST_OFF;
                    end
                ST_OFF:
                    if (tmr_zero && last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (tmr_zero) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= ST_FETCH;
                    end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr = addr_q;
    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step     = busy_q ? {1'b0, addr_q} : '0;

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: timeline model of the playback schedule plus directed literal checks.
module tb_sequence_player;

    localparam int AW   = 3;
    localparam int ONC  = 3;
    localparam int OFFC = 2;
    localparam int P    = 1 + ONC + OFFC;

    logic          clk = 0, reset = 1, start = 0, abort = 0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_data;
    logic [3:0]    led;
    logic          busy, done;
    logic [AW:0]   step;

    logic [1:0] mem [8] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    assign mem_data = mem[mem_addr];

    always #5 clk = ~clk;

    sequence_player #(.ADDR_W(AW), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .length   (length),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .step     (step)
    );

    int total = 0, bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] led_of(input logic [1:0] c);
        case (c)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    // Model: m_t counts cycles since the accepted start; every step takes P cycles, DONE sits at t = n*P.
    bit m_act = 0;
    int m_t = 0, m_n = 0, m_addr = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act  <= 0;
            m_t    <= 0;
            m_addr <= 0;
        end else if (m_act) begin
            if (abort || m_t >= m_n * P) m_act <= 0;
            else begin
                m_t <= m_t + 1;
                if (m_t + 1 < m_n * P) m_addr <= (m_t + 1) / P;
            end
        end else if (start && !abort) begin
            m_act <= 1;
            m_t   <= 0;
            m_n   <= (length > 8) ? 8 : int'(length);
            if (length != 0) m_addr <= 0;
        end
    end

    task automatic compare_model();
        logic [3:0] e_led = '0;
        bit e_busy = 0, e_done = 0;
        int e_step = 0;
        if (m_act && m_t == m_n * P) e_done = 1;
        else if (m_act) begin
            e_busy = 1;
            e_step = m_t / P;
            e_led  = (m_t % P >= 1 && m_t % P <= ONC) ? led_of(mem[e_step]) : 4'b0000;
        end
        chk("led", 32'(led), 32'(e_led));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("step", 32'(step), e_step);
        chk("mem_addr", 32'(mem_addr), m_addr);
    endtask

    always @(negedge clk) if (chk_en) compare_model();

    int done_at, done_n;
    bit busy_seen;
    logic [3:0]    led_log  [0:63];
    logic [AW-1:0] addr_log [0:63];

    // abort_at = 0 raises abort together with start; pulse_at re-pulses start with a new length mid-play.
    task automatic run(input int len, input int cyc, input int abort_at, input int pulse_at);
        @(negedge clk);
        start  = 1;
        length = len[AW:0];
        abort  = (abort_at == 0);
        done_at = -1; done_n = 0; busy_seen = 0;
        for (int i = 1; i <= cyc; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            if (i == pulse_at) length = 4'd5;
            abort = (i == abort_at);
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            busy_seen |= busy;
            led_log[i]  = led;
            addr_log[i] = mem_addr;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_step", 32'(step), 0);
        reset  = 0;
        chk_en = 1;

        run(3, 22, -1, 0);
        chk("t1_done_at", done_at, 19);
        chk("t1_done_n", done_n, 1);
        chk("t1_led2", 32'(led_log[2]), 32'h4);
        chk("t1_led4", 32'(led_log[4]), 32'h4);
        chk("t1_led5", 32'(led_log[5]), 32'h0);
        chk("t1_led8", 32'(led_log[8]), 32'h2);
        chk("t1_led14", 32'(led_log[14]), 32'h8);
        chk("t1_led17", 32'(led_log[17]), 32'h0);
        chk("t1_addr7", 32'(addr_log[7]), 1);
        chk("t1_addr13", 32'(addr_log[13]), 2);

        run(0, 4, -1, 0);
        chk("t2_done_at", done_at, 1);
        chk("t2_busy_seen", 32'(busy_seen), 0);

        run(12, 55, -1, 0);
        chk("t3_done_at", done_at, 49);
        chk("t3_addr48", 32'(addr_log[48]), 7);
        chk("t3_addr50", 32'(addr_log[50]), 7);

        run(3, 15, 8, 0);
        chk("t4_led9", 32'(led_log[9]), 0);
        chk("t4_done_n", done_n, 0);
        run(1, 10, -1, 0);
        chk("t4b_led2", 32'(led_log[2]), 32'h4);
        chk("t4b_addr2", 32'(addr_log[2]), 0);
        chk("t4b_done_at", done_at, 7);

        run(2, 16, -1, 3);
        chk("t5_done_n", done_n, 1);
        chk("t5_done_at", done_at, 13);
        chk("t5_led8", 32'(led_log[8]), 32'h2);

        run(2, 4, 0, 0);
        chk("t6_busy_seen", 32'(busy_seen), 0);
        chk("t6_done_n", done_n, 0);

        @(negedge clk);
        start  = 1;
        length = 4'd3;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            start = 0;
        end
        chk("t7_busy_pre", 32'(busy), 1);
        #2 reset = 1;
        #1;
        chk("t7_led", 32'(led), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_done", 32'(done), 0);
        chk("t7_addr", 32'(mem_addr), 0);
        chk("t7_step", 32'(step), 0);
        #3 reset = 0;
        run(1, 8, -1, 0);
        chk("t7b_led2", 32'(led_log[2]), 32'h4);
        chk("t7b_addr1", 32'(addr_log[1]), 0);
        chk("t7b_done_at", done_at, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_player.md
# sequence_player

Timed playback engine for the Simon colour sequence. On `start` it walks the stored pattern from address 0 to `length-1`, reads each 2-bit colour from the sequence memory, and lights the matching one-hot LED for a fixed on-time followed by a dark gap. It sits between the sequence memory (`eeprom`) and the LED outputs, in place of per-key stepping. The control FSM hands it the current level and waits for `done` before entering compare.

## Interface
- `ADDR_W`, 3: sequence memory address width; maximum length is 2^ADDR_W.
- `ON_CYCLES`, 25_000_000: cycles each colour is lit; must be ≥1.
- `OFF_CYCLES`, 12_500_000: dark cycles after each colour; must be ≥1.
- `CNT_W`, 26: timer width; must hold max(ON_CYCLES, OFF_CYCLES)-1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to play; honoured only in IDLE.
- `abort`  in  1  cancel playback; highest priority after reset.
- `length`  in  ADDR_W+1  number of steps to play; sampled on accepted `start`.
- `mem_addr`  out  ADDR_W  registered read address to the sequence memory.
- `mem_data`  in  2  colour at `mem_addr`; combinational (same-cycle) read.
- `led`  out  4  one-hot colour: 00→0001 B, 01→0010 G, 10→0100 R, 11→1000 Y; 0000 when dark.
- `busy`  out  1  high from the cycle after accepted `start` until DONE.
- `done`  out  1  one-cycle pulse when playback completes normally.
- `step`  out  ADDR_W+1  index of the step currently playing, for the HEX display.

## Operation
- States: IDLE, FETCH, ON, OFF, DONE.
- IDLE:
  - `start` with `length`≠0: latch `len = min(length, 2^ADDR_W)`, set `idx=0`, `mem_addr=0`, go to FETCH.
  - `start` with `length`=0: go to DONE.
- FETCH (1 cycle): capture `mem_data` into `colour`, load the timer with ON_CYCLES-1, go to ON.
- ON: `led = onehot(colour)`. When the timer hits 0, load OFF_CYCLES-1 and go to OFF. Otherwise decrement.
- OFF: `led = 0`. When the timer hits 0:
  - if `idx == len-1`, go to DONE;
  - else increment `idx`, set `mem_addr = idx+1`, go to FETCH.
- DONE (1 cycle): `done=1`, `busy=0`, go to IDLE.
- `abort` in any non-IDLE state: next state IDLE, `led=0`, no `done`. Counters are not cleared until the next `start`.
- `start` outside IDLE is ignored. `length` changes after acceptance are ignored.
- `step = idx` while busy, 0 in IDLE.
- Simultaneous `start` and `abort` in IDLE: `abort` wins, stay IDLE.
- `mem_addr` never wraps: `idx` stops at `len-1` ≤ 2^ADDR_W-1.

## Timing
- Reset values: state=IDLE, `led`=0000, `busy`=0, `done`=0, `mem_addr`=0, `step`=0, timer=0.
- `led` and `busy` are registered outputs (state-decoded from registers).
- Accepted `start` at edge k: FETCH during cycle k+1; LED lit from cycle k+2 for exactly ON_CYCLES cycles; then OFF_CYCLES dark cycles.
- Per-step period: 1 + ON_CYCLES + OFF_CYCLES cycles.
- Total from `start` to `done` = N·(1+ON_CYCLES+OFF_CYCLES) + 1 cycles, for N = `len`.
- `length`=0: `done` is high in the cycle after `start`.
- Reset mid-play: outputs return to reset values immediately (asynchronous), independent of `clk`.

## Structure
- Shared package `simon_pkg`:
  - colour codes B/G/R/Y (2'b00..2'b11);
  - state encoding localparams;
  - `onehot_colour` function, also used by `show_color`.
- Sub-module `play_timer`: loadable down-counter (`load`, `load_val`, `zero`) of width CNT_W, shared by the ON and OFF phases.

## Test plan
All with ON_CYCLES=3, OFF_CYCLES=2, memory preloaded 0:R, 1:G, 2:Y, 3:B.
- `start`, `length`=3: `led` shows 0100×3, 0000×2, 0010×3, 0000×2, 1000×3, 0000×2; `done` pulses at cycle 19 after `start`; `mem_addr` sequence 0,1,2.
- `start`, `length`=0: `done`=1 on the next cycle, `busy` never high, `led` stays 0000.
- `start`, `length`=12 with ADDR_W=3: clamped to 8, `mem_addr` reaches 7 and never wraps to 0, `done` after 8·6+1=49 cycles.
- `abort` in the second ON phase: `led`=0000 and state IDLE on the next cycle, no `done`; a fresh `start`, `length`=1 then plays R only.
- `start` pulsed again while busy, plus `length` changed mid-play: sequence and length unaffected, a single `done`.
- `reset` asserted between clock edges during OFF: outputs reach reset values before the next edge; after release, `start` plays from address 0.
